// File: rtl/pwl_dma_source_if.sv
// Shared DAQ width parameters and the AXI-Stream bundle used between the DMA source and the PWL generator.
// Master drives data/valid/last; slave drives ready.
package daq_params_pkg;
    localparam int DMA_DATA_WIDTH = 32;
endpackage

interface Axis_IF #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  last;
    logic                  ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/pwl_dma_source.sv
// Buffers one PWL wave from a load port and replays it as an AXI-Stream packet with optional idle gaps.
// First beat 2 cycles after start; 1 beat/cycle at gap 0; held beats stay stable while ready is low.
module pwl_dma_source #(
    parameter int DMA_DATA_WIDTH = daq_params_pkg::DMA_DATA_WIDTH,
    parameter int DEPTH          = 256,
    parameter int GAP_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DMA_DATA_WIDTH-1:0] wr_data,
    input  logic                      wr_valid,
    input  logic                      wr_last,
    output logic                      wr_rdy,
    input  logic [GAP_WIDTH-1:0]      gap_cycles,
    input  logic                      start,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(DEPTH):0]    word_count,
    Axis_IF.master                    dma
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {EMPTY, LOADING, LOADED, SEND, GAP} state_t;
    state_t state, state_nxt;

    logic [DMA_DATA_WIDTH-1:0] mem [DEPTH];
    logic [DMA_DATA_WIDTH-1:0] mem_q;
    logic                      pend, pend_last;
    logic [DMA_DATA_WIDTH-1:0] out_dat, ra_dat;
    logic                      out_vld, out_last, ra_vld, ra_last;
    logic [CW-1:0]             rd_ptr;
    logic [GAP_WIDTH-1:0]      gap_q, gap_cnt;
    logic                      abort_pend;

    logic          wr_fire, wr_first, load_done;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wc_new;
    logic          dma_vld, pop, cut, keep_busy, issue, avail;
    logic [1:0]    occ;

    assign wr_fire   = wr_valid && wr_rdy;
    assign wr_first  = (state == EMPTY) || (state == LOADED);
    assign wr_addr   = wr_first ? '0 : word_count[AW-1:0];
    assign wc_new    = wr_first ? CW'(1) : word_count + CW'(1);
    assign load_done = wr_last || (wc_new == CW'(DEPTH));

    assign dma_vld   = (state == SEND) && out_vld;
    assign pop       = dma_vld && dma.ready;
    assign cut       = abort_pend || abort;
    assign busy      = (state == SEND) || (state == GAP);

    // Read-ahead: at most two words live between BRAM output and the outgoing beat.
    assign occ       = 2'(out_vld) + 2'(ra_vld) + 2'(pend);
    assign avail     = (occ - 2'(pop)) < 2'd2;
    assign keep_busy = (state_nxt == SEND) || (state_nxt == GAP);
    assign issue     = keep_busy && (rd_ptr < word_count) && avail;

    assign dma.data  = out_dat;
    assign dma.valid = dma_vld;
    assign dma.last  = dma_vld && (out_last || cut);

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY, LOADING: begin
                if (wr_fire) state_nxt = load_done ? LOADED : LOADING;
            end
            LOADED: begin
                if (wr_fire)              state_nxt = load_done ? LOADED : LOADING;
                else if (start && !abort) state_nxt = SEND;
            end
            SEND: begin
                if (pop) begin
                    if (out_last || cut)    state_nxt = LOADED;
                    else if (gap_q != '0)   state_nxt = GAP;
                end else if (abort && !out_vld) begin
                    state_nxt = LOADED;
                end
            end
            GAP: begin
                if (abort)                            state_nxt = LOADED;
                else if (gap_cnt == GAP_WIDTH'(1))    state_nxt = SEND;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_addr] <= wr_data;
        if (issue)   mem_q <= mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            wr_rdy     <= 1'b0;
            done       <= 1'b0;
            word_count <= '0;
            out_dat    <= '0;
            out_vld    <= 1'b0;
            out_last   <= 1'b0;
            ra_dat     <= '0;
            ra_vld     <= 1'b0;
            ra_last    <= 1'b0;
            pend       <= 1'b0;
            pend_last  <= 1'b0;
            rd_ptr     <= '0;
            gap_q      <= '0;
            gap_cnt    <= '0;
            abort_pend <= 1'b0;
        end else begin
            state  <= state_nxt;
            wr_rdy <= (state_nxt == EMPTY) || (state_nxt == LOADING) || (state_nxt == LOADED);
            done   <= pop && out_last;
            if (wr_fire) word_count <= wc_new;
            if (state == LOADED && state_nxt == SEND) gap_q <= gap_cycles;
            if (state == SEND && state_nxt == GAP) gap_cnt <= gap_q;
            else if (state == GAP)                 gap_cnt <= gap_cnt - GAP_WIDTH'(1);

            if (!keep_busy) begin
                out_vld    <= 1'b0;
                out_last   <= 1'b0;
                ra_vld     <= 1'b0;
                pend       <= 1'b0;
                rd_ptr     <= '0;
                abort_pend <= 1'b0;
            end else begin
                pend      <= issue;
                pend_last <= (rd_ptr == word_count - CW'(1));
                if (issue) rd_ptr <= rd_ptr + CW'(1);
                if (state == SEND && abort && out_vld) abort_pend <= 1'b1;
                if (pop) begin
                    if (ra_vld) begin
                        out_dat  <= ra_dat;
                        out_last <= ra_last;
                        ra_vld   <= 1'b0;
                    end else if (pend) begin
                        out_dat  <= mem_q;
                        out_last <= pend_last;
                    end else begin
                        out_vld  <= 1'b0;
                    end
                end else if (pend) begin
                    if (out_vld) begin
                        ra_dat  <= mem_q;
                        ra_last <= pend_last;
                        ra_vld  <= 1'b1;
                    end else begin
                        out_dat  <= mem_q;
                        out_last <= pend_last;
                        out_vld  <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pwl_dma_source.sv
// Directed bench for pwl_dma_source: table-driven packet timing plus hand-written abort/reset/depth sequences.
module tb_pwl_dma_source;
    logic        clk;
    logic        rst;
    logic [31:0] wr_data;
    logic        wr_valid, wr_last, wr_rdy;
    logic [7:0]  gap_cycles;
    logic        start, abort, busy, done;
    logic [8:0]  word_count;

    Axis_IF #(.DATA_WIDTH(32)) dma_if ();

    pwl_dma_source #(.DMA_DATA_WIDTH(32), .DEPTH(256), .GAP_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_last(wr_last),
        .wr_rdy(wr_rdy), .gap_cycles(gap_cycles), .start(start), .abort(abort),
        .busy(busy), .done(done), .word_count(word_count), .dma(dma_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] rx_dat[$];
    logic        rx_last[$];
    int          rx_cyc[$];
    int          done_cyc;

    typedef struct {
        logic        start;
        logic        ready;
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        dn;
        logic        b;
    } vec_t;
    vec_t tbl[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic load(input int n, input logic [31:0] base, input logic mark_last);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + 32'(i);
            wr_last  = mark_last && (i == n - 1);
            tick();
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    // Pulses start at cycle 0, drives ready from pat, records handshakes and watches hold stability.
    task automatic send(input logic [7:0] gap, input logic [31:0] pat, input int limit);
        logic pv, pr, pl;
        logic [31:0] pd;
        rx_dat.delete(); rx_last.delete(); rx_cyc.delete();
        done_cyc = -1;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        gap_cycles = gap;
        for (int c = 0; c < limit && done_cyc < 0; c++) begin
            start        = (c == 0);
            dma_if.ready = pat[c % 32];
            #1;
            if (pv && !pr) begin
                chk("hold_valid", 32'(dma_if.valid), 32'd1);
                chk("hold_data", dma_if.data, pd);
                chk("hold_last", 32'(dma_if.last), 32'(pl));
            end
            if (dma_if.valid && dma_if.ready) begin
                rx_dat.push_back(dma_if.data);
                rx_last.push_back(dma_if.last);
                rx_cyc.push_back(c);
            end
            if (done) done_cyc = c;
            pv = dma_if.valid; pr = dma_if.ready; pd = dma_if.data; pl = dma_if.last;
            tick();
        end
        start = 1'b0;
        dma_if.ready = 1'b0;
        if (done_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: no done within %0d cycles", limit);
        end
    endtask

    task automatic check_packet(input int n, input logic [31:0] base, input string tag);
        chk({tag, "_beats"}, 32'(rx_dat.size()), 32'(n));
        for (int i = 0; i < n && i < rx_dat.size(); i++) begin
            chk({tag, "_data"}, rx_dat[i], base + 32'(i));
            chk({tag, "_last"}, 32'(rx_last[i]), 32'(i == n - 1));
        end
    endtask

    task automatic empty_start(input string tag);
        logic seen;
        seen = 1'b0;
        start = 1'b1;
        dma_if.ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dma_if.valid || done) seen = 1'b1;
            tick();
        end
        dma_if.ready = 1'b0;
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h11, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h12, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h13, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 32'h15, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; wr_data = '0; wr_valid = 1'b0; wr_last = 1'b0;
        gap_cycles = '0; start = 1'b0; abort = 1'b0; dma_if.ready = 1'b0;
        repeat (3) tick();
        chk("rst_wr_rdy", 32'(wr_rdy), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_valid", 32'(dma_if.valid), 32'd0);
        chk("rst_last", 32'(dma_if.last), 32'd0);
        chk("rst_data", dma_if.data, 32'd0);
        rst = 1'b0;
        chk("wr_rdy_before_edge", 32'(wr_rdy), 32'd0);
        tick();
        chk("wr_rdy_after_release", 32'(wr_rdy), 32'd1);

        empty_start("empty_start_quiet");

        load(5, 32'h11, 1'b1);
        chk("load5_word_count", 32'(word_count), 32'd5);
        chk("load5_idle", 32'(busy), 32'd0);

        for (int r = 0; r < 9; r++) begin
            start = tbl[r].start;
            dma_if.ready = tbl[r].ready;
            #1;
            chk($sformatf("tbl%0d_valid", r), 32'(dma_if.valid), 32'(tbl[r].v));
            if (tbl[r].v) chk($sformatf("tbl%0d_data", r), dma_if.data, tbl[r].d);
            chk($sformatf("tbl%0d_last", r), 32'(dma_if.last), 32'(tbl[r].l));
            chk($sformatf("tbl%0d_done", r), 32'(done), 32'(tbl[r].dn));
            chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].b));
            chk($sformatf("tbl%0d_word_count", r), 32'(word_count), 32'd5);
            tick();
        end
        start = 1'b0;
        dma_if.ready = 1'b0;

        send(8'd3, 32'hFFFF_FFFF, 100);
        check_packet(5, 32'h11, "gap3");
        if (rx_cyc.size() == 5) begin
            chk("gap3_first_cycle", 32'(rx_cyc[0]), 32'd2);
            for (int i = 1; i < 5; i++) chk("gap3_spacing", 32'(rx_cyc[i] - rx_cyc[i-1]), 32'd4);
            chk("gap3_span", 32'(rx_cyc[4] - rx_cyc[0] + 1), 32'd17);
        end
        chk("gap3_done_cycle", 32'(done_cyc), 32'd19);

        send(8'd0, 32'hB2D9_6E53, 200);
        check_packet(5, 32'h11, "toggle_a");
        send(8'd0, 32'hB2D9_6E53, 200);
        check_packet(5, 32'h11, "toggle_b");

        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", 32'(busy), 32'd0);
        tick();
        chk("abort_start_valid", 32'(dma_if.valid), 32'd0);

        load(256, 32'h1000, 1'b0);
        chk("full_word_count", 32'(word_count), 32'd256);
        send(8'd0, 32'hFFFF_FFFF, 400);
        check_packet(256, 32'h1000, "full");
        load(1, 32'hABC, 1'b1);
        chk("wrap_word_count", 32'(word_count), 32'd1);
        send(8'd0, 32'hFFFF_FFFF, 50);
        check_packet(1, 32'hABC, "wrap");

        load(10, 32'h100, 1'b1);
        gap_cycles = '0;
        for (int c = 0; c < 11; c++) begin
            start        = (c == 0);
            dma_if.ready = (c < 5) || (c >= 8);
            abort        = (c == 6);
            #1;
            if (c == 4) chk("abort_pre_data", dma_if.data, 32'h102);
            if (c == 5) chk("abort_pending_last", 32'(dma_if.last), 32'd0);
            if (c >= 5 && c <= 8) begin
                chk("abort_held_valid", 32'(dma_if.valid), 32'd1);
                chk("abort_held_data", dma_if.data, 32'h103);
            end
            if (c >= 6 && c <= 8) chk("abort_forced_last", 32'(dma_if.last), 32'd1);
            if (c == 9) begin
                chk("abort_busy_after", 32'(busy), 32'd0);
                chk("abort_valid_after", 32'(dma_if.valid), 32'd0);
            end
            if (c >= 9) chk("abort_no_done", 32'(done), 32'd0);
            tick();
        end
        start = 1'b0; abort = 1'b0; dma_if.ready = 1'b0;
        send(8'd0, 32'hFFFF_FFFF, 50);
        check_packet(10, 32'h100, "after_abort");

        gap_cycles = '0;
        start = 1'b1; dma_if.ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("mid_valid_before_rst", 32'(dma_if.valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(dma_if.valid), 32'd0);
        chk("mid_rst_last", 32'(dma_if.last), 32'd0);
        chk("mid_rst_word_count", 32'(word_count), 32'd0);
        chk("mid_rst_wr_rdy", 32'(wr_rdy), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        dma_if.ready = 1'b0;
        tick();
        chk("mid_rst_wr_rdy_release", 32'(wr_rdy), 32'd1);
        empty_start("post_rst_start_quiet");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
